// File: rtl/uart_rx_monitor.sv
// UART receiver with mid-bit sampling, start-glitch rejection, optional parity,
// sticky framing/parity/overrun flags and a small receive FIFO on a valid/ready read port.
module uart_rx_monitor #(
  parameter int CLK_PER_BIT = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  input  logic                             rx,
  output logic                             rd_valid,
  output logic [DATA_BITS-1:0]             rd_data,
  input  logic                             rd_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             frame_err,
  output logic                             parity_err,
  output logic                             overrun,
  input  logic                             err_clr
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] HALF_CNT = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLK_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic                   rx_meta_q, rxs_q;
  logic                   seen_high_q, seen_high_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_acc_q, par_acc_d;
  logic                   par_bad_q, par_bad_d;

  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;

  logic                   frame_err_q, frame_err_d;
  logic                   parity_err_q, parity_err_d;
  logic                   overrun_q, overrun_d;

  logic                   push_req, frame_set, par_set;
  logic                   pop, push, full, ovr_set;

  // Receive FSM: the bit counter restarts at every sample point so each
  // subsequent sample lands one full bit time later, centred on the bit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_acc_d   = par_acc_q;
    par_bad_d   = par_bad_q;
    seen_high_d = seen_high_q | rxs_q;
    push_req    = 1'b0;
    frame_set   = 1'b0;
    par_set     = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs_q && seen_high_q) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d     = '0;
          bit_d     = '0;
          par_acc_d = 1'b0;
          par_bad_d = 1'b0;
          state_d   = rxs_q ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d     = '0;
          shift_d   = {rxs_q, shift_q[DATA_BITS-1:1]};
          par_acc_d = par_acc_q ^ rxs_q;
          bit_d     = bit_q + 1'b1;
          if (bit_q == LAST_BIT) begin
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end
        end
      end

      S_PAR: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d     = '0;
          par_bad_d = (PARITY == 1) ? ~(par_acc_q ^ rxs_q) : (par_acc_q ^ rxs_q);
          state_d   = S_STOP;
        end
      end

      S_STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          // A low stop bit also arms the line-high requirement so a held
          // break yields a single framing error.
          if (!rxs_q) begin
            frame_set   = 1'b1;
            seen_high_d = 1'b0;
          end else if (par_bad_q) begin
            par_set = 1'b1;
          end else begin
            push_req = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign rd_valid = (level_q != '0);
  assign pop      = rd_valid && rd_ready;
  assign full     = (level_q == FULL_LVL);
  // A pop in the same cycle frees the slot the push needs.
  assign push     = push_req && (!full || pop);
  assign ovr_set  = push_req && full && !pop;

  always_comb begin
    wr_ptr_d     = wr_ptr_q + PW'(push);
    rd_ptr_d     = rd_ptr_q + PW'(pop);
    level_d      = level_q + LW'(push) - LW'(pop);
    frame_err_d  = frame_set | (frame_err_q  & ~err_clr);
    parity_err_d = par_set   | (parity_err_q & ~err_clr);
    overrun_d    = ovr_set   | (overrun_q    & ~err_clr);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rx_meta_q    <= 1'b1;
      rxs_q        <= 1'b1;
      seen_high_q  <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_acc_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rxs_q        <= rx_meta_q;
      seen_high_q  <= seen_high_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_acc_q    <= par_acc_d;
      par_bad_q    <= par_bad_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level = level_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule
